y86_writeback: RTL and testbench

- Final stage of the pipelined Y86-64 core, directly downstream of the Memory stage.
- Holds the W pipeline register, which captures the Memory-stage results (stat, icode, valE, valM, dstE, dstM).
- Holds the 15-entry x 64-bit program register file and performs the two write-backs (E and M ports).
- Drives combinational read ports for Decode, the W-stage forwarding signals, the sticky processor status/halt, and a retired-instruction counter.

---
 rtl/y86_writeback.sv | 154 +++++++++++++++
 tb/tb_y86_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_writeback.sv
// Y86-64 writeback stage: W pipeline register, 15x64 register file, sticky status and retire count.
// Define REGFILE_BYPASS_EN to let read ports see the value being written in the same cycle.
module y86_writeback #(
    parameter int unsigned NREGS = 15,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_stall,
    input  logic             w_bubble,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [3:0]       W_icode,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [63:0]      W_valE,
    output logic [63:0]      W_valM,
    output logic [1:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] IcodeNop = 4'h1;
    localparam logic [3:0] RegNone  = 4'hF;
    localparam logic [1:0] StatAok  = 2'd0;

    logic [1:0]       w_stat_q, w_stat_d;
    logic [3:0]       w_icode_q, w_icode_d;
    logic [63:0]      w_vale_q, w_vale_d;
    logic [63:0]      w_valm_q, w_valm_d;
    logic [3:0]       w_dste_q, w_dste_d;
    logic [3:0]       w_dstm_q, w_dstm_d;
    // Set while the W entry is on its first resident edge; keeps stalled repeats out of the count.
    logic             w_fresh_q, w_fresh_d;
    logic [1:0]       stat_q, stat_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [63:0]      regs_q [NREGS];
    logic [63:0]      regs_d [NREGS];
    logic             wr_en;

    assign wr_en = !halted_q && (w_stat_q == StatAok);

    // W pipeline register next state
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        w_fresh_d = w_fresh_q;
        if (reset || (!halted_q && !w_stall && w_bubble)) begin
            w_stat_d  = StatAok;
            w_icode_d = IcodeNop;
            w_vale_d  = '0;
            w_valm_d  = '0;
            w_dste_d  = RegNone;
            w_dstm_d  = RegNone;
            w_fresh_d = 1'b1;
        end else if (!halted_q && !w_stall) begin
            w_stat_d  = m_stat;
            w_icode_d = m_icode;
            w_vale_d  = m_valE;
            w_valm_d  = m_valM;
            w_dste_d  = m_dstE;
            w_dstm_d  = m_dstM;
            w_fresh_d = 1'b1;
        end else if (!halted_q) begin
            w_fresh_d = 1'b0;
        end
    end

    // Register file writes; the M port is applied last so it wins on a shared destination.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (w_dste_q == 4'(i))) regs_d[i] = w_vale_q;
            if (wr_en && (w_dstm_q == 4'(i))) regs_d[i] = w_valm_q;
            if (reset) regs_d[i] = '0;
        end
    end

    // Status, halt and retire counter
    always_comb begin
        stat_d    = stat_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (reset) begin
            stat_d    = StatAok;
            halted_d  = 1'b0;
            retired_d = '0;
        end else if (!halted_q) begin
            if (w_stat_q != StatAok) begin
                stat_d   = w_stat_q;
                halted_d = 1'b1;
            end else if (w_icode_q != IcodeNop && w_fresh_q) begin
                retired_d = retired_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        w_stat_q  <= w_stat_d;
        w_icode_q <= w_icode_d;
        w_vale_q  <= w_vale_d;
        w_valm_q  <= w_valm_d;
        w_dste_q  <= w_dste_d;
        w_dstm_q  <= w_dstm_d;
        w_fresh_q <= w_fresh_d;
        stat_q    <= stat_d;
        halted_q  <= halted_d;
        retired_q <= retired_d;
        regs_q    <= regs_d;
    end

    // Combinational read ports; RNONE and out-of-range IDs read as zero.
    always_comb begin
        d_rvalA = '0;
        d_rvalB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (d_srcA == 4'(i)) d_rvalA = regs_q[i];
            if (d_srcB == 4'(i)) d_rvalB = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && d_srcA != RegNone) begin
            if (d_srcA == w_dstm_q)      d_rvalA = w_valm_q;
            else if (d_srcA == w_dste_q) d_rvalA = w_vale_q;
        end
        if (wr_en && d_srcB != RegNone) begin
            if (d_srcB == w_dstm_q)      d_rvalB = w_valm_q;
            else if (d_srcB == w_dste_q) d_rvalB = w_vale_q;
        end
`endif
    end

    assign W_icode = w_icode_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign stat    = halted_q ? stat_q : w_stat_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_y86_writeback.sv
// Scoreboard bench for y86_writeback: expected register contents are queued and checked on read-back.
module tb_y86_writeback;

    logic        clock = 1'b0;
    logic        reset, w_stall, w_bubble;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode, m_dstE, m_dstM, d_srcA, d_srcB;
    logic [63:0] m_valE, m_valM;
    logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic [1:0]  stat;
    logic        halted;
    logic [31:0] retired;

    typedef struct {
        logic [3:0]  r;
        logic [63:0] v;
    } sb_t;
    sb_t sb[$];

    int tests_run = 0;
    int tests_failed = 0;

    y86_writeback #(.NREGS(15), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .w_stall(w_stall), .w_bubble(w_bubble),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .W_icode(W_icode), .W_dstE(W_dstE),
        .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM), .stat(stat),
        .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        m_stat = st; m_icode = ic; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
    endtask

    task automatic drive_nop();
        drive(2'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    endtask

    // Pop every queued expectation and compare it against a read through port A.
    task automatic drain_sb(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d_srcA = e.r;
            #1;
            tests_run++;
            if (d_rvalA !== e.v) begin
                $display("FAIL %s reg%0d: got %h expected %h", tag, e.r, d_rvalA, e.v);
                tests_failed++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (W_icode !== 4'h1 || W_dstE !== 4'hF || W_dstM !== 4'hF || W_valE !== 64'h0 ||
            W_valM !== 64'h0) begin
            $display("FAIL reset_w: got icode=%h dstE=%h dstM=%h valE=%h valM=%h expected 1 f f 0 0",
                     W_icode, W_dstE, W_dstM, W_valE, W_valM);
            tests_failed++;
        end
        tests_run++;
        if (stat !== 2'd0 || halted !== 1'b0 || retired !== 32'd0) begin
            $display("FAIL reset_status: got stat=%0d halted=%0b retired=%0d expected 0 0 0",
                     stat, halted, retired);
            tests_failed++;
        end
        sb.push_back('{4'd0, 64'h0});
        sb.push_back('{4'd14, 64'h0});
        drain_sb("reset_regs");
    endtask

    task automatic test_write_read();
        drive(2'd0, 4'h3, 4'd0, 64'h10, 4'hF, 64'h0);
        tick();
        tests_run++;
        if (W_valE !== 64'h10 || W_icode !== 4'h3) begin
            $display("FAIL capture: got valE=%h icode=%h expected 10 3", W_valE, W_icode);
            tests_failed++;
        end
        drive_nop();
        tick();
        tests_run++;
        if (retired !== 32'd1) begin
            $display("FAIL retire_first: got %0d expected 1", retired);
            tests_failed++;
        end
        sb.push_back('{4'd0, 64'h10});
        drain_sb("write_read");
    endtask

    task automatic test_popq();
        drive(2'd0, 4'hB, 4'd4, 64'h100, 4'd4, 64'h200);
        tick();
        drive_nop();
        tick();
        sb.push_back('{4'd4, 64'h200});
        drain_sb("popq_m_wins");
        tests_run++;
        if (retired !== 32'd2) begin
            $display("FAIL retire_popq: got %0d expected 2", retired);
            tests_failed++;
        end
    endtask

    task automatic test_stall_bubble();
        drive(2'd0, 4'h6, 4'd3, 64'h33, 4'hF, 64'h0);
        tick();
        w_stall = 1'b1; w_bubble = 1'b1;
        drive(2'd0, 4'h2, 4'd5, 64'h55, 4'hF, 64'h0);
        tick();
        tests_run++;
        if (W_icode !== 4'h6 || W_valE !== 64'h33 || retired !== 32'd3) begin
            $display("FAIL stall_hold: got icode=%h valE=%h retired=%0d expected 6 33 3",
                     W_icode, W_valE, retired);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (W_icode !== 4'h6 || retired !== 32'd3) begin
            $display("FAIL stall_repeat: got icode=%h retired=%0d expected 6 3", W_icode, retired);
            tests_failed++;
        end
        w_stall = 1'b0;
        tick();
        w_bubble = 1'b0;
        drive_nop();
        tests_run++;
        if (W_icode !== 4'h1 || W_dstE !== 4'hF || retired !== 32'd3) begin
            $display("FAIL bubble: got icode=%h dstE=%h retired=%0d expected 1 f 3",
                     W_icode, W_dstE, retired);
            tests_failed++;
        end
        sb.push_back('{4'd3, 64'h33});
        sb.push_back('{4'd5, 64'h0});
        drain_sb("stall_bubble");
    endtask

    task automatic test_halt();
        drive(2'd2, 4'h3, 4'd1, 64'h55, 4'hF, 64'h0);
        tick();
        tests_run++;
        if (stat !== 2'd2 || halted !== 1'b0) begin
            $display("FAIL halt_pre: got stat=%0d halted=%0b expected 2 0", stat, halted);
            tests_failed++;
        end
        drive(2'd0, 4'h6, 4'd1, 64'h77, 4'hF, 64'h0);
        tick();
        tests_run++;
        if (stat !== 2'd2 || halted !== 1'b1 || retired !== 32'd3) begin
            $display("FAIL halt_set: got stat=%0d halted=%0b retired=%0d expected 2 1 3",
                     stat, halted, retired);
            tests_failed++;
        end
        drive(2'd0, 4'h3, 4'd2, 64'h99, 4'hF, 64'h0);
        tick();
        tick();
        tests_run++;
        if (stat !== 2'd2 || halted !== 1'b1 || W_icode !== 4'h6 || retired !== 32'd3) begin
            $display("FAIL halt_sticky: got stat=%0d halted=%0b icode=%h retired=%0d expected 2 1 6 3",
                     stat, halted, W_icode, retired);
            tests_failed++;
        end
        sb.push_back('{4'd1, 64'h0});
        sb.push_back('{4'd2, 64'h0});
        drain_sb("halt_no_write");
        drive_nop();
        do_reset();
        tests_run++;
        if (stat !== 2'd0 || halted !== 1'b0) begin
            $display("FAIL halt_reset: got stat=%0d halted=%0b expected 0 0", stat, halted);
            tests_failed++;
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 64'hABCD;
`else
        exp_same = 64'h0;
`endif
        drive(2'd0, 4'h3, 4'd2, 64'hABCD, 4'hF, 64'h0);
        tick();
        drive_nop();
        d_srcB = 4'd2;
        #1;
        tests_run++;
        if (d_rvalB !== exp_same) begin
            $display("FAIL bypass_same_cycle: got %h expected %h", d_rvalB, exp_same);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (d_rvalB !== 64'hABCD) begin
            $display("FAIL bypass_after: got %h expected abcd", d_rvalB);
            tests_failed++;
        end
        d_srcB = 4'hF;
        #1;
        tests_run++;
        if (d_rvalB !== 64'h0) begin
            $display("FAIL rnone_read: got %h expected 0", d_rvalB);
            tests_failed++;
        end
    endtask

    task automatic test_reset_midstream();
        drive(2'd0, 4'h3, 4'd7, 64'h7777, 4'hF, 64'h0);
        tick();
        drive(2'd0, 4'h5, 4'hF, 64'h0, 4'd8, 64'h8888);
        tick();
        drive(2'd0, 4'h6, 4'd9, 64'h9999, 4'hF, 64'h0);
        tick();
        drive_nop();
        tick();
        sb.push_back('{4'd7, 64'h7777});
        sb.push_back('{4'd8, 64'h8888});
        sb.push_back('{4'd9, 64'h9999});
        drain_sb("pre_reset");
        tests_run++;
        if (retired !== 32'd4) begin
            $display("FAIL pre_reset_retired: got %0d expected 4", retired);
            tests_failed++;
        end
        drive(2'd0, 4'h3, 4'd10, 64'hAAAA, 4'hF, 64'h0);
        do_reset();
        drive_nop();
        tests_run++;
        if (W_icode !== 4'h1 || retired !== 32'd0) begin
            $display("FAIL mid_reset: got icode=%h retired=%0d expected 1 0", W_icode, retired);
            tests_failed++;
        end
        for (int i = 0; i < 15; i++) sb.push_back('{4'(i), 64'h0});
        drain_sb("mid_reset_regs");
    endtask

    initial begin
        reset = 1'b1; w_stall = 1'b0; w_bubble = 1'b0;
        d_srcA = 4'hF; d_srcB = 4'hF;
        drive_nop();
        test_reset();
        test_write_read();
        test_popq();
        test_stall_bubble();
        test_halt();
        test_bypass();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
